// File: rtl/drive_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : drive_sequencer
//  Purpose  : Frame-synchronous sequencer between the target tracker and the
//             motor control loop. Latches tracker data on each valid frame,
//             gives the control loop a settle window, then registers its
//             speed/turn command. Ramps the motors down when the target is
//             lost and stops them if frames stop arriving.
//  Revision : 1.0 - initial release
// ============================================================================
module drive_sequencer #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int MIN_RAD         = 4,
  parameter int LOST_FRAMES     = 8,
  parameter int RAMP_STEP       = 8,
  parameter int WATCHDOG_CYCLES = 6500000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  input  logic              frame_done_in,
  input  logic [8:0]        cur_pos_x_in,
  input  logic [8:0]        cur_pos_y_in,
  input  logic [23:0]       cur_rad_in,
  input  logic signed [8:0] speed_in,
  input  logic signed [8:0] turn_in,
  output logic              ctrl_ready_out,
  output logic [8:0]        pos_x_out,
  output logic [8:0]        pos_y_out,
  output logic [23:0]       rad_out,
  output logic signed [8:0] speed_out,
  output logic signed [8:0] turn_out,
  output logic              motor_en_out,
  output logic              lost_out,
  output logic [2:0]        state_out
);

  // Counter widths; each is at least one bit so degenerate parameters still elaborate.
  localparam int SW = (SETTLE_CYCLES > 1)   ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int MW = (LOST_FRAMES > 1)     ? $clog2(LOST_FRAMES + 1)   : 1;
  localparam int WW = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES)   : 1;

  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYCLES);
  localparam logic [MW-1:0]     MISS_LIMIT  = MW'(LOST_FRAMES);
  localparam logic [WW-1:0]     WD_LAST     = WW'(WATCHDOG_CYCLES - 1);
  localparam logic [23:0]       RAD_MIN     = 24'(MIN_RAD);
  localparam logic signed [9:0] STEP        = 10'(RAMP_STEP);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    SETTLE     = 3'd2,
    LOST       = 3'd3,
    STOP       = 3'd4
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [MW-1:0] miss_cnt;
  logic [WW-1:0] wd_cnt;
  logic          pending;

  logic          frame_event;
  logic          rad_ok;
  logic          wd_expired;
  logic [MW-1:0] miss_inc;
  logic signed [8:0] speed_ramped;
  logic signed [8:0] turn_ramped;

  // Move a signed command toward zero by STEP without crossing zero.
  function automatic logic signed [8:0] ramp_to_zero(input logic signed [8:0] v);
    logic signed [9:0] wide;
    wide = {v[8], v};
    if (wide > STEP) begin
      wide = wide - STEP;
    end else if (wide < -STEP) begin
      wide = wide + STEP;
    end else begin
      wide = '0;
    end
    return wide[8:0];
  endfunction

  // Frame qualification, saturating miss increment and ramped commands.
  always_comb begin
    frame_event  = frame_done_in | pending;
    rad_ok       = (cur_rad_in >= RAD_MIN);
    wd_expired   = (wd_cnt == WD_LAST);
    miss_inc     = (miss_cnt == MISS_LIMIT) ? miss_cnt : miss_cnt + 1'b1;
    speed_ramped = ramp_to_zero(speed_out);
    turn_ramped  = ramp_to_zero(turn_out);
  end

  assign state_out = state;

  // Sequencer: single state register with all outputs registered alongside it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      ctrl_ready_out <= 1'b0;
      pos_x_out      <= '0;
      pos_y_out      <= '0;
      rad_out        <= '0;
      speed_out      <= '0;
      turn_out       <= '0;
      motor_en_out   <= 1'b0;
      lost_out       <= 1'b0;
      settle_cnt     <= '0;
      miss_cnt       <= '0;
      wd_cnt         <= '0;
      pending        <= 1'b0;
    end else begin
      // The ready strobe is a single-cycle pulse unless re-armed below.
      ctrl_ready_out <= 1'b0;

      if (!enable_in) begin
        // Dropping enable overrides everything, including a coincident frame.
        state        <= IDLE;
        pos_x_out    <= '0;
        pos_y_out    <= '0;
        rad_out      <= '0;
        speed_out    <= '0;
        turn_out     <= '0;
        motor_en_out <= 1'b0;
        lost_out     <= 1'b0;
        settle_cnt   <= '0;
        miss_cnt     <= '0;
        wd_cnt       <= '0;
        pending      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT_FRAME;
          end

          WAIT_FRAME: begin
            // A frame deferred from SETTLE is consumed here, on the first cycle.
            pending <= 1'b0;
            if (frame_event) begin
              wd_cnt <= '0;
              if (rad_ok) begin
                pos_x_out      <= cur_pos_x_in;
                pos_y_out      <= cur_pos_y_in;
                rad_out        <= cur_rad_in;
                ctrl_ready_out <= 1'b1;
                miss_cnt       <= '0;
                settle_cnt     <= '0;
                state          <= SETTLE;
              end else begin
                miss_cnt <= miss_inc;
                if (miss_inc == MISS_LIMIT) begin
                  lost_out <= 1'b1;
                  state    <= LOST;
                end
              end
            end else if (wd_expired) begin
              wd_cnt       <= '0;
              speed_out    <= '0;
              turn_out     <= '0;
              motor_en_out <= 1'b0;
              state        <= STOP;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end

          SETTLE: begin
            // One-deep memory of a frame that arrives while the loop settles.
            if (frame_done_in) begin
              pending <= 1'b1;
            end
            if (settle_cnt == SETTLE_LAST) begin
              speed_out    <= speed_in;
              turn_out     <= turn_in;
              motor_en_out <= 1'b1;
              settle_cnt   <= '0;
              wd_cnt       <= '0;
              state        <= WAIT_FRAME;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end

          LOST: begin
            if (frame_done_in) begin
              wd_cnt <= '0;
              if (rad_ok) begin
                pos_x_out      <= cur_pos_x_in;
                pos_y_out      <= cur_pos_y_in;
                rad_out        <= cur_rad_in;
                ctrl_ready_out <= 1'b1;
                miss_cnt       <= '0;
                settle_cnt     <= '0;
                lost_out       <= 1'b0;
                state          <= SETTLE;
              end else begin
                // Each further miss ramps both commands toward a standstill.
                speed_out    <= speed_ramped;
                turn_out     <= turn_ramped;
                motor_en_out <= motor_en_out &
                                ((speed_ramped != 9'sd0) || (turn_ramped != 9'sd0));
              end
            end else if (wd_expired) begin
              wd_cnt       <= '0;
              speed_out    <= '0;
              turn_out     <= '0;
              motor_en_out <= 1'b0;
              lost_out     <= 1'b0;
              state        <= STOP;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end

          STOP: begin
            // The frame that wakes us only re-arms; it is not processed.
            if (frame_done_in) begin
              wd_cnt   <= '0;
              miss_cnt <= '0;
              state    <= WAIT_FRAME;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
